reg_to_obi_bridge: RTL and testbench



---
 rtl/eros_pkg.sv | 28 ++
 rtl/reg_pkg.sv | 18 +
 rtl/reg_to_obi_bridge_if.sv | 17 +
 rtl/reg_to_obi_bridge.sv | 149 ++++++++++++++
 tb/tb_reg_to_obi_bridge.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eros_pkg.sv
// Bridge-local types: OBI request/response structs, FSM state encoding, error read data.
package eros_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } eros_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } eros_obi_resp_t;

  typedef enum logic [2:0] {
    R2O_IDLE,
    R2O_REQ,
    R2O_WAIT,
    R2O_RESP,
    R2O_DRAIN
  } reg2obi_state_e;

  localparam logic [31:0] REG2OBI_ERR_RDATA = 32'h0;

endpackage

// File: rtl/reg_pkg.sv
// Register-interface request/response types shared by CSR-side agents.
package reg_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } reg_rsp_t;

endpackage

// File: rtl/reg_to_obi_bridge_if.sv
// Signal bundle around the bridge: register side, OBI master side and status.
interface reg_to_obi_bridge_if;
  import reg_pkg::*;
  import eros_pkg::*;

  reg_req_t       reg_req;
  reg_rsp_t       reg_rsp;
  eros_obi_req_t  obi_req;
  eros_obi_resp_t obi_resp;
  logic           busy;
  logic           timeout;

  // master: the bridge itself; slave: the register agent plus OBI target around it
  modport master (input reg_req, obi_resp, output reg_rsp, obi_req, busy, timeout);
  modport slave  (output reg_req, obi_resp, input reg_rsp, obi_req, busy, timeout);

endinterface

// File: rtl/reg_to_obi_bridge.sv
// Register-interface to OBI initiator bridge: one reg_req transaction is replayed as a
// single OBI master access, bounded by a budget counter so a dead slave cannot hang.
module reg_to_obi_bridge
  import reg_pkg::*;
  import eros_pkg::*;
#(
  parameter type         obi_req_t      = eros_obi_req_t,
  parameter type         obi_resp_t     = eros_obi_resp_t,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  reg_req_t  reg_req_i,
  output reg_rsp_t  reg_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_resp_i,
  output logic      busy_o,
  output logic      timeout_o
);

  localparam int unsigned      CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  reg2obi_state_e   state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [3:0]       be_q, be_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             stale_q, stale_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             expired;
  logic             resp_vld;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  // >= rather than ==: a grant on the last budget cycle leaves WAIT already past budget
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_EXP);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    be_d      = be_q;
    we_d      = we_q;
    err_d     = err_q;
    stale_d   = stale_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      R2O_IDLE: begin
        cnt_d = '0;
        if (reg_req_i.valid) begin
          addr_d  = reg_req_i.addr;
          wdata_d = reg_req_i.wdata;
          we_d    = reg_req_i.write;
          be_d    = reg_req_i.write ? reg_req_i.wstrb : 4'hF;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = R2O_REQ;
        end
      end
      R2O_REQ: begin
        cnt_d = cnt_inc;
        if (obi_resp_i.gnt) begin
          state_d = R2O_WAIT;
        end else if (expired) begin
          err_d     = 1'b1;
          rdata_d   = REG2OBI_ERR_RDATA;
          timeout_d = 1'b1;
          state_d   = R2O_RESP;
        end
      end
      R2O_WAIT: begin
        cnt_d = cnt_inc;
        if (obi_resp_i.rvalid) begin
          rdata_d = we_q ? 32'h0 : obi_resp_i.rdata;
          state_d = R2O_RESP;
        end else if (expired) begin
          // the slave still owes an rvalid; DRAIN must swallow it later
          err_d     = 1'b1;
          rdata_d   = REG2OBI_ERR_RDATA;
          stale_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = R2O_RESP;
        end
      end
      R2O_RESP: begin
        cnt_d   = '0;
        state_d = stale_q ? R2O_DRAIN : R2O_IDLE;
      end
      R2O_DRAIN: begin
        cnt_d = cnt_inc;
        if (obi_resp_i.rvalid || expired) begin
          stale_d = 1'b0;
          state_d = R2O_IDLE;
        end
      end
      default: state_d = R2O_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= R2O_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      stale_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    obi_req_o       = '0;
    obi_req_o.req   = (state_q == R2O_REQ);
    obi_req_o.we    = we_q;
    obi_req_o.be    = be_q;
    obi_req_o.addr  = addr_q;
    obi_req_o.wdata = wdata_q;
  end

  assign resp_vld        = (state_q == R2O_RESP);
  assign reg_rsp_o.ready = resp_vld;
  assign reg_rsp_o.error = resp_vld & err_q;
  assign reg_rsp_o.rdata = resp_vld ? rdata_q : 32'h0;
  assign busy_o          = (state_q != R2O_IDLE);
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_reg_to_obi_bridge.sv
// Directed bench for reg_to_obi_bridge: two instances (budget 16 and 8) driven by one
// register-master/OBI-slave model, responses checked through a scoreboard queue.
module tb_reg_to_obi_bridge;
  import reg_pkg::*;
  import eros_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_ni;
  bit   sel;
  int   checks;
  int   errors;
  exp_t sb[$];

  reg_req_t       req_drv;
  eros_obi_resp_t resp_drv;
  reg_rsp_t       rsp;
  eros_obi_req_t  oreq;
  logic           busy;
  logic           tmo;

  reg_to_obi_bridge_if ifa ();
  reg_to_obi_bridge_if ifb ();

  reg_to_obi_bridge #(.TIMEOUT_CYCLES(16)) u_dut16 (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .reg_req_i  (ifa.reg_req),
    .reg_rsp_o  (ifa.reg_rsp),
    .obi_req_o  (ifa.obi_req),
    .obi_resp_i (ifa.obi_resp),
    .busy_o     (ifa.busy),
    .timeout_o  (ifa.timeout)
  );

  reg_to_obi_bridge #(.TIMEOUT_CYCLES(8)) u_dut8 (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .reg_req_i  (ifb.reg_req),
    .reg_rsp_o  (ifb.reg_rsp),
    .obi_req_o  (ifb.obi_req),
    .obi_resp_i (ifb.obi_resp),
    .busy_o     (ifb.busy),
    .timeout_o  (ifb.timeout)
  );

  always_comb begin
    ifa.reg_req       = req_drv;
    ifa.reg_req.valid = req_drv.valid & ~sel;
    ifb.reg_req       = req_drv;
    ifb.reg_req.valid = req_drv.valid & sel;
  end

  assign ifa.obi_resp = resp_drv;
  assign ifb.obi_resp = resp_drv;
  assign rsp  = sel ? ifb.reg_rsp : ifa.reg_rsp;
  assign oreq = sel ? ifb.obi_req : ifa.obi_req;
  assign busy = sel ? ifb.busy    : ifa.busy;
  assign tmo  = sel ? ifb.timeout : ifa.timeout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_w({tag, "_obi"}, 128'(oreq), 128'(0));
    check_w({tag, "_rsp"}, 128'(rsp), 128'(0));
    check_b({tag, "_busy"}, busy, 1'b0);
    check_b({tag, "_tmo"}, tmo, 1'b0);
  endtask

  // One transaction: register master on cycle 0, OBI slave granting at cycle 1+gnt_dly
  // and returning rvalid rv_dly cycles after the grant.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int gnt_dly, input int rv_dly, input logic [31:0] sl_rdata);
    int            tc;
    int            g_cyc;
    int            r_cyc;
    int            wt;
    int            exp_ready;
    int            exp_idle;
    int            d;
    bit            err;
    bit            stale;
    bit            done;
    exp_t          e;
    exp_t          got;
    eros_obi_req_t exp_o;

    tc    = sel ? 8 : 16;
    g_cyc = 1 + gnt_dly;
    r_cyc = g_cyc + rv_dly;
    stale = 1'b0;
    if (g_cyc > tc) begin
      err       = 1'b1;
      exp_ready = tc + 1;
    end else begin
      wt = (tc > g_cyc + 1) ? tc : g_cyc + 1;
      if (r_cyc <= wt) begin
        err       = 1'b0;
        exp_ready = r_cyc + 1;
      end else begin
        err       = 1'b1;
        stale     = 1'b1;
        exp_ready = wt + 1;
      end
    end
    if (stale) begin
      d        = exp_ready + 1;
      exp_idle = (r_cyc >= d && r_cyc <= d + tc - 1) ? r_cyc + 1 : d + tc;
    end else begin
      exp_idle = exp_ready + 1;
    end

    e.err   = err;
    e.rdata = (err || wr) ? 32'h0 : sl_rdata;
    sb.push_back(e);
    exp_o = '{req: 1'b1, we: wr, be: (wr ? wstrb : 4'hF), addr: addr, wdata: wdata};

    @(negedge clk);
    check_b({tag, "_busy0"}, busy, 1'b0);
    req_drv  = '{valid: 1'b1, write: wr, addr: addr, wdata: wdata, wstrb: wstrb};
    resp_drv = '0;

    done = 1'b0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      resp_drv = '0;
      check_b({tag, "_req"}, oreq.req, (cyc <= g_cyc && cyc <= tc) ? 1'b1 : 1'b0);
      if (oreq.req) check_w({tag, "_fields"}, 128'(oreq), 128'(exp_o));
      if (cyc == g_cyc) resp_drv.gnt = 1'b1;
      if (cyc == r_cyc) begin
        resp_drv.rvalid = 1'b1;
        resp_drv.rdata  = sl_rdata;
      end
      check_b({tag, "_ready"}, rsp.ready, (cyc == exp_ready) ? 1'b1 : 1'b0);
      check_b({tag, "_timeout"}, tmo, (err && cyc == exp_ready) ? 1'b1 : 1'b0);
      check_b({tag, "_busy"}, busy, (cyc < exp_idle) ? 1'b1 : 1'b0);
      if (rsp.ready) begin
        req_drv.valid = 1'b0;
        if (sb.size() == 0) begin
          check_w({tag, "_sb_empty"}, 128'(0), 128'(1));
        end else begin
          got = sb.pop_front();
          check_b({tag, "_error"}, rsp.error, got.err);
          check_w({tag, "_rdata"}, 128'(rsp.rdata), 128'(got.rdata));
        end
      end
      if (cyc >= exp_idle) done = 1'b1;
    end
    req_drv.valid = 1'b0;
    resp_drv      = '0;
    check_b({tag, "_finished"}, done, 1'b1);
    check_w({tag, "_sb_left"}, 128'(sb.size()), 128'(0));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    sel      = 1'b0;
    rst_ni   = 1'b0;
    req_drv  = '0;
    resp_drv = '0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset16");
    sel = 1'b1;
    #1;
    check_idle_outputs("reset8");
    sel = 1'b0;
    rst_ni = 1'b1;

    // budget 16
    run_txn("rd_zero_wait", 1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF);
    run_txn("wr_zero_wait", 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 0, 1, 32'hFFFF_FFFF);
    run_txn("rd_gnt_dly5", 1'b0, 32'h0000_3008, 32'h0, 4'h0, 5, 1, 32'hA5A5_0001);
    run_txn("wr_rv_dly3", 1'b1, 32'h0000_300C, 32'hCAFE_0042, 4'b1100, 2, 3, 32'h0);

    // budget 8
    @(negedge clk);
    sel = 1'b1;
    run_txn("no_grant", 1'b0, 32'h0000_4000, 32'h0, 4'h0, 1000, 1, 32'h1111_1111);
    check_b("no_grant_req_after", oreq.req, 1'b0);
    run_txn("late_rvalid", 1'b0, 32'h0000_5000, 32'h0, 4'h0, 0, 10, 32'hBAD0_BAD0);
    run_txn("after_drain", 1'b0, 32'h0000_5004, 32'h0, 4'h0, 0, 1, 32'h600D_F00D);
    run_txn("rv_on_expiry", 1'b0, 32'h0000_5008, 32'h0, 4'h0, 0, 7, 32'h7777_0008);
    run_txn("gnt_on_expiry", 1'b0, 32'h0000_500C, 32'h0, 4'h0, 7, 1, 32'h8888_0009);
    run_txn("gnt_expiry_to", 1'b1, 32'h0000_5010, 32'hFEED_0001, 4'b0001, 7, 2, 32'h0);
    run_txn("after_expiry", 1'b0, 32'h0000_5014, 32'h0, 4'h0, 1, 2, 32'h1357_9BDF);

    // reset during WAIT on the budget-16 instance
    @(negedge clk);
    sel      = 1'b0;
    #1;
    req_drv  = '{valid: 1'b1, write: 1'b0, addr: 32'h0000_0040, wdata: 32'h0, wstrb: 4'h0};
    resp_drv = '0;
    @(negedge clk);
    check_b("rst_req_high", oreq.req, 1'b1);
    resp_drv.gnt = 1'b1;
    @(negedge clk);
    resp_drv = '0;
    check_b("rst_in_wait", busy & ~oreq.req, 1'b1);
    rst_ni        = 1'b0;
    req_drv.valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_b("rst_no_ready", rsp.ready, 1'b0);
      check_b("rst_stay_idle", busy, 1'b0);
    end
    run_txn("rd_after_rst", 1'b0, 32'h0000_1008, 32'h0, 4'h0, 0, 1, 32'h0BAD_CAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
